// File: rtl/mdll_sel_sequencer.sv
// Select sequencer for the multiplying-DLL ring mux. It counts output-clock slots in
// N-periods and M-groups, holds the ring for the reference on the last slot, then injects.
module mdll_sel_sequencer #(
    parameter int N_W     = 4,
    parameter int M_W     = 2,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           ref_edge,
    input  logic [N_W-1:0] n_cfg,
    input  logic [M_W-1:0] m_cfg,
    input  logic           clr_flags,
    output logic [1:0]     sel,
    output logic           div_n,
    output logic           div_m,
    output logic           inject,
    output logic           ref_miss,
    output logic           ref_early,
    output logic [N_W-1:0] n_count,
    output logic [M_W-1:0] m_count
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_INJECT, S_RUN} state_t;

    localparam logic [1:0]       SEL_INJ  = 2'b00;
    localparam logic [1:0]       SEL_FB   = 2'b01;
    localparam logic [1:0]       SEL_HOLD = 2'b10;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    function automatic logic [N_W-1:0] floor_n(input logic [N_W-1:0] v);
        return (v == '0) ? N_W'(1) : v;
    endfunction

    function automatic logic [M_W-1:0] floor_m(input logic [M_W-1:0] v);
        return (v == '0) ? M_W'(1) : v;
    endfunction

    state_t           state;
    logic [N_W-1:0]   ne, n_eff, n_last, n_inc;
    logic [M_W-1:0]   me, m_eff, m_last, m_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic             n_wrap, next_is_last;

    // Shadows follow cfg only in IDLE and during INJECT; otherwise the group runs on the latched values.
    always_comb begin
        n_eff        = ne;
        m_eff        = me;
        if (state == S_IDLE || state == S_INJECT) begin
            n_eff = floor_n(n_cfg);
            m_eff = floor_m(m_cfg);
        end
        n_last       = n_eff - 1'b1;
        m_last       = m_eff - 1'b1;
        n_wrap       = (n_count == n_last);
        n_inc        = n_wrap ? '0 : n_count + 1'b1;
        m_inc        = m_count;
        if (n_wrap)
            m_inc = (m_count == m_last) ? '0 : m_count + 1'b1;
        next_is_last = (n_inc == n_last) && (m_inc == m_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel       <= SEL_FB;
            div_n     <= 1'b0;
            div_m     <= 1'b0;
            inject    <= 1'b0;
            ref_miss  <= 1'b0;
            ref_early <= 1'b0;
            n_count   <= '0;
            m_count   <= '0;
            tmo_cnt   <= '0;
            ne        <= floor_n(n_cfg);
            me        <= floor_m(m_cfg);
        end else begin
            ne     <= n_eff;
            me     <= m_eff;
            sel    <= SEL_FB;
            div_n  <= 1'b0;
            div_m  <= 1'b0;
            inject <= 1'b0;

            // Clear first so that a coincident set event overrides it.
            if (clr_flags) begin
                ref_miss  <= 1'b0;
                ref_early <= 1'b0;
            end
            if (ref_edge && (state == S_RUN || state == S_INJECT))
                ref_early <= 1'b1;

            if (!enable) begin
                state   <= S_IDLE;
                n_count <= '0;
                m_count <= '0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_ARM;
                        sel     <= SEL_HOLD;
                        div_n   <= 1'b1;
                        div_m   <= 1'b1;
                        n_count <= n_last;
                        m_count <= m_last;
                        tmo_cnt <= '0;
                    end
                    S_INJECT, S_RUN: begin
                        if (next_is_last) begin
                            state   <= S_ARM;
                            sel     <= SEL_HOLD;
                            div_n   <= 1'b1;
                            div_m   <= 1'b1;
                            n_count <= n_last;
                            m_count <= m_last;
                            tmo_cnt <= '0;
                        end else begin
                            state   <= S_RUN;
                            n_count <= n_inc;
                            m_count <= m_inc;
                            div_n   <= (n_inc == n_last);
                        end
                    end
                    S_ARM: begin
                        if (ref_edge) begin
                            state   <= S_INJECT;
                            sel     <= SEL_INJ;
                            inject  <= 1'b1;
                            n_count <= '0;
                            m_count <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            // No reference: free-run from slot 0 on the feedback path.
                            state    <= S_RUN;
                            ref_miss <= 1'b1;
                            n_count  <= '0;
                            m_count  <= '0;
                            div_n    <= (n_last == '0);
                            div_m    <= (n_last == '0) && (m_last == '0);
                        end else begin
                            sel     <= SEL_HOLD;
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdll_sel_sequencer.sv
// Directed bench for mdll_sel_sequencer: reset, aligned/late reference, timeout,
// minimum period, config shadowing, enable drop and mid-operation reset.
module tb_mdll_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, enable, ref_edge, clr_flags;
    logic [3:0] n_cfg;
    logic [1:0] m_cfg;
    logic [1:0] sel;
    logic       div_n, div_m, inject, ref_miss, ref_early;
    logic [3:0] n_count;
    logic [1:0] m_count;

    int tests = 0;
    int fails = 0;

    logic [10:0] obs, exp_v;
    logic [1:0]  esel;
    logic        edn, edm, einj;
    logic [3:0]  en;
    logic [1:0]  em;
    logic        bad;

    always #5 clk = ~clk;

    mdll_sel_sequencer #(.N_W(4), .M_W(2), .TMO_W(8), .TMO_CYC(200)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ref_edge(ref_edge),
        .n_cfg(n_cfg), .m_cfg(m_cfg), .clr_flags(clr_flags),
        .sel(sel), .div_n(div_n), .div_m(div_m), .inject(inject),
        .ref_miss(ref_miss), .ref_early(ref_early),
        .n_count(n_count), .m_count(m_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; ref_edge = 1'b0; clr_flags = 1'b0;
        n_cfg = 4'd4; m_cfg = 2'd2;
        repeat (3) tick();
        obs = {sel, div_n, div_m, inject, n_count, m_count};
        tests++;
        if (obs !== {2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", obs, {2'b01, 3'b000, 4'd0, 2'd0});
        end
        tests++;
        if ({ref_miss, ref_early} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00", {ref_miss, ref_early});
        end
        rst_n = 1'b1; enable = 1'b1;
        tick();
        obs = {sel, div_n, div_m, inject, n_count, m_count};
        tests++;
        if (obs !== {2'b10, 1'b1, 1'b1, 1'b0, 4'd3, 2'd1}) begin
            fails++;
            $display("FAIL first_arm: got %b want %b", obs, {2'b10, 3'b110, 4'd3, 2'd1});
        end
    endtask

    task automatic test_aligned();
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 8; s++) begin
                ref_edge = (s == 0);
                tick();
                esel = (s == 0) ? 2'b00 : ((s == 7) ? 2'b10 : 2'b01);
                edn  = (s == 3) || (s == 7);
                edm  = (s == 7);
                einj = (s == 0);
                en   = 4'(s % 4);
                em   = 2'(s / 4);
                obs   = {sel, div_n, div_m, inject, n_count, m_count};
                exp_v = {esel, edn, edm, einj, en, em};
                tests++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL aligned p%0d slot %0d: got %b want %b", p, s, obs, exp_v);
                end
            end
        end
        ref_edge = 1'b0;
        tests++;
        if ({ref_miss, ref_early} !== 2'b00) begin
            fails++;
            $display("FAIL aligned_flags: got %b want 00", {ref_miss, ref_early});
        end
    endtask

    task automatic test_late_ref();
        ref_edge = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({sel, div_n, div_m} !== {2'b10, 2'b00}) begin
                fails++;
                $display("FAIL late_hold %0d: got %b want 1000", i, {sel, div_n, div_m});
            end
        end
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        tests++;
        if ({sel, inject, n_count, m_count} !== {2'b00, 1'b1, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL late_inject: got %b want %b", {sel, inject, n_count, m_count}, {2'b00, 1'b1, 6'd0});
        end
        repeat (6) tick();
        tests++;
        if (sel !== 2'b01) begin
            fails++;
            $display("FAIL late_slot6: got %b want 01", sel);
        end
        tick();
        tests++;
        if ({sel, ref_miss, ref_early} !== 4'b1000) begin
            fails++;
            $display("FAIL late_slot7: got %b want 1000", {sel, ref_miss, ref_early});
        end
    endtask

    task automatic test_timeout();
        ref_edge = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < 200; i++) begin
            tick();
            if (sel !== 2'b10 || ref_miss !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL tmo_hold: got early exit or flag, want 200 ARM cycles at sel 10");
        end
        tick();
        tests++;
        if ({sel, ref_miss, n_count, m_count} !== {2'b01, 1'b1, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL tmo_expire: got %b want %b", {sel, ref_miss, n_count, m_count}, {2'b01, 1'b1, 6'd0});
        end
        for (int k = 1; k < 7; k++) begin
            tick();
            obs   = {5'b0, sel, n_count, m_count};
            exp_v = {5'b0, 2'b01, 4'(k % 4), 2'(k / 4)};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL freerun slot %0d: got %b want %b", k, obs, exp_v);
            end
        end
        tick();
        tests++;
        if ({sel, n_count, m_count} !== {2'b10, 4'd3, 2'd1}) begin
            fails++;
            $display("FAIL freerun_arm: got %b want %b", {sel, n_count, m_count}, {2'b10, 4'd3, 2'd1});
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++;
        if ({sel, ref_miss} !== 3'b100) begin
            fails++;
            $display("FAIL tmo_clear: got %b want 100", {sel, ref_miss});
        end
        repeat (198) tick();
        // This is the 200th ARM cycle: a reference here must beat the timeout.
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        tests++;
        if ({sel, ref_miss} !== 3'b000) begin
            fails++;
            $display("FAIL tmo_vs_ref: got %b want 000", {sel, ref_miss});
        end
    endtask

    task automatic test_min_period();
        n_cfg = 4'd1; m_cfg = 2'd1;
        tick();
        tests++;
        if ({sel, div_n, div_m, n_count, m_count} !== {2'b10, 2'b11, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL n1_first_arm: got %b want %b", {sel, div_n, div_m, n_count, m_count}, {2'b10, 2'b11, 6'd0});
        end
        for (int i = 0; i < 6; i++) begin
            ref_edge = (i % 2 == 0);
            tick();
            esel = (i % 2 == 0) ? 2'b00 : 2'b10;
            tests++;
            if (sel !== esel) begin
                fails++;
                $display("FAIL n1_alt %0d: got %b want %b", i, sel, esel);
            end
        end
        n_cfg = 4'd0;
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        tick();
        tests++;
        if ({sel, n_count, m_count} !== {2'b10, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL n0_arm: got %b want %b", {sel, n_count, m_count}, {2'b10, 6'd0});
        end
        ref_edge = 1'b1;
        tick();
        tests++;
        if (sel !== 2'b00) begin
            fails++;
            $display("FAIL n0_inject: got %b want 00", sel);
        end
        // Reference during INJECT, with a simultaneous clear that must lose.
        ref_edge = 1'b1; clr_flags = 1'b1;
        tick();
        ref_edge = 1'b0; clr_flags = 1'b0;
        tests++;
        if ({sel, ref_early} !== 3'b101) begin
            fails++;
            $display("FAIL early_set: got %b want 101", {sel, ref_early});
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++;
        if (ref_early !== 1'b0) begin
            fails++;
            $display("FAIL early_clear: got %b want 0", ref_early);
        end
    endtask

    task automatic test_cfg_shadow();
        n_cfg = 4'd4; m_cfg = 2'd2;
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        tick();
        n_cfg = 4'd6;
        for (int s = 2; s < 8; s++) begin
            tick();
            esel  = (s == 7) ? 2'b10 : 2'b01;
            edn   = (s == 3) || (s == 7);
            edm   = (s == 7);
            obs   = {sel, div_n, div_m, 1'b0, n_count, m_count};
            exp_v = {esel, edn, edm, 1'b0, 4'(s % 4), 2'(s / 4)};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL shadow_old slot %0d: got %b want %b", s, obs, exp_v);
            end
        end
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        for (int s = 1; s < 12; s++) begin
            tick();
            esel  = (s == 11) ? 2'b10 : 2'b01;
            edn   = (s == 5) || (s == 11);
            edm   = (s == 11);
            obs   = {sel, div_n, div_m, inject, n_count, m_count};
            exp_v = {esel, edn, edm, 1'b0, 4'(s % 6), 2'(s / 6)};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL shadow_new slot %0d: got %b want %b", s, obs, exp_v);
            end
        end
        enable = 1'b0;
        tick();
        obs = {sel, div_n, div_m, inject, n_count, m_count};
        tests++;
        if (obs !== {2'b01, 3'b000, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL disable_arm: got %b want %b", obs, {2'b01, 3'b000, 6'd0});
        end
        enable = 1'b1;
        tick();
        tests++;
        if ({sel, n_count, m_count} !== {2'b10, 4'd5, 2'd1}) begin
            fails++;
            $display("FAIL reenable: got %b want %b", {sel, n_count, m_count}, {2'b10, 4'd5, 2'd1});
        end
    endtask

    task automatic test_mid_reset();
        ref_edge = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ref_edge = 1'b0;
        obs = {sel, div_n, div_m, inject, n_count, m_count};
        tests++;
        if ({obs, ref_early, ref_miss} !== {2'b01, 3'b000, 4'd0, 2'd0, 2'b00}) begin
            fails++;
            $display("FAIL mid_reset: got %b want %b", {obs, ref_early, ref_miss}, {2'b01, 3'b000, 6'd0, 2'b00});
        end
        tick();
        tests++;
        if (sel !== 2'b10) begin
            fails++;
            $display("FAIL post_reset_arm: got %b want 10", sel);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_late_ref();
        test_timeout();
        test_min_period();
        test_cfg_shadow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
